// File: rtl/lane_to_fifo_bridge.sv
// rtl/lane_to_fifo_bridge.sv - DSI lane RX bytes to FIFO words with sop/eop, mode hold and overflow drop
module lane_to_fifo_bridge #(
  parameter int REVERSE_BITS = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lane_active,
  input  logic                 lane_valid,
  input  logic [7:0]           lane_data,
  input  logic                 lane_mode_lp,
  output logic [9:0]           fifo_data,
  output logic                 fifo_write,
  input  logic                 fifo_full,
  output logic                 mode_lp,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic [CNT_WIDTH-1:0] pkt_cnt
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 stg_valid_q, stg_valid_d;
  logic [7:0]           stg_byte_q, stg_byte_d;
  logic                 stg_sop_q, stg_sop_d;
  logic                 mode_q, mode_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [7:0] lane_byte;
  logic       write_needed;
  logic       write_eop;
  logic       lost;

  // Undo lane bit order so the stage always holds the byte in FIFO order
  always_comb begin
    lane_byte = lane_data;
    if (REVERSE_BITS != 0) begin
      for (int i = 0; i < 8; i++) begin
        lane_byte[i] = lane_data[7-i];
      end
    end
  end

  // Burst FSM: one-byte stage delays each write until we know whether it is the last
  always_comb begin
    state_d      = state_q;
    stg_valid_d  = stg_valid_q;
    stg_byte_d   = stg_byte_q;
    stg_sop_d    = stg_sop_q;
    mode_d       = mode_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    write_needed = 1'b0;
    write_eop    = 1'b0;
    lost         = 1'b0;

    case (state_q)
      ST_WAIT: begin
        // A burst already in flight at reset is never captured
        if (!lane_active) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (lane_active) begin
          state_d = ST_RECV;
          mode_d  = lane_mode_lp;
          if (lane_valid) begin
            stg_valid_d = 1'b1;
            stg_byte_d  = lane_byte;
            stg_sop_d   = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (!lane_active) begin
          state_d     = ST_IDLE;
          stg_valid_d = 1'b0;
          if (stg_valid_q) begin
            write_needed = 1'b1;
            write_eop    = 1'b1;
            if (fifo_full) lost = 1'b1;
            else           cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else if (lane_valid) begin
          if (stg_valid_q) begin
            write_needed = 1'b1;
            if (fifo_full) begin
              // Packet is now corrupt; discard the rest of the burst
              lost        = 1'b1;
              stg_valid_d = 1'b0;
              state_d     = ST_DROP;
            end else begin
              stg_byte_d = lane_byte;
              stg_sop_d  = 1'b0;
            end
          end else begin
            stg_valid_d = 1'b1;
            stg_byte_d  = lane_byte;
            stg_sop_d   = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!lane_active) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT;
    endcase

    // A new loss outranks a simultaneous clear
    if (ovf_clr) ovf_d = 1'b0;
    if (lost)    ovf_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      stg_valid_q <= 1'b0;
      stg_byte_q  <= 8'h00;
      stg_sop_q   <= 1'b0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      stg_valid_q <= stg_valid_d;
      stg_byte_q  <= stg_byte_d;
      stg_sop_q   <= stg_sop_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fifo_write = write_needed & ~fifo_full & ~rst;
  assign fifo_data  = {write_eop, stg_sop_q, stg_byte_q};
  assign mode_lp    = mode_q;
  assign busy       = (state_q == ST_RECV) || (state_q == ST_DROP);
  assign overflow   = ovf_q;
  assign pkt_cnt    = cnt_q;

endmodule

// File: tb/tb_lane_to_fifo_bridge.sv
// tb/tb_lane_to_fifo_bridge.sv - scoreboard bench for lane_to_fifo_bridge
module tb_lane_to_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       lane_active;
  logic       lane_valid;
  logic [7:0] lane_data;
  logic       lane_mode_lp;
  logic [9:0] fifo_data;
  logic       fifo_write;
  logic       fifo_full;
  logic       mode_lp;
  logic       busy;
  logic       overflow;
  logic       ovf_clr;
  logic [3:0] pkt_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  lane_to_fifo_bridge #(.REVERSE_BITS(1), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .lane_active(lane_active), .lane_valid(lane_valid),
    .lane_data(lane_data), .lane_mode_lp(lane_mode_lp), .fifo_data(fifo_data),
    .fifo_write(fifo_write), .fifo_full(fifo_full), .mode_lp(mode_lp), .busy(busy),
    .overflow(overflow), .ovf_clr(ovf_clr), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1 and hold for one full clock
  task automatic drive(input logic a, input logic v, input logic [7:0] d,
                       input logic m, input logic f);
    lane_active  = a;
    lane_valid   = v;
    lane_data    = d;
    lane_mode_lp = m;
    fifo_full    = f;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT write is matched against the head of the expected queue
  always @(negedge clk) begin
    if (fifo_write === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (fifo_data !== e) begin
          miscompares++;
          $display("FAIL write_data: got %0h expected %0h", fifo_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ovf_clr = 1'b0;
    lane_active = 1'b0; lane_valid = 1'b0; lane_data = 8'h00;
    lane_mode_lp = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", {31'd0, fifo_write}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_cnt", {28'd0, pkt_cnt}, 0);
    check("rst_mode", {31'd0, mode_lp}, 0);
    check("rst_data", {22'd0, fifo_data}, 0);
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0);

    // 3-byte HS burst
    exp_q.push_back(10'h180); exp_q.push_back(10'h001); exp_q.push_back(10'h2C3);
    drive(1, 1, 8'h01, 0, 0);
    check("busy_recv", {31'd0, busy}, 1);
    drive(1, 1, 8'h80, 0, 0);
    drive(1, 1, 8'hC3, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("t1_cnt", {28'd0, pkt_cnt}, 1);
    check("t1_busy", {31'd0, busy}, 0);

    // 1-byte LP burst, back to back
    exp_q.push_back(10'h3F0);
    drive(1, 1, 8'h0F, 1, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("t2_mode", {31'd0, mode_lp}, 1);
    check("t2_cnt", {28'd0, pkt_cnt}, 2);

    // 5-byte burst, FIFO full on the 2nd write
    exp_q.push_back(10'h180);
    drive(1, 1, 8'h01, 0, 0);
    drive(1, 1, 8'h02, 0, 0);
    drive(1, 1, 8'h03, 0, 1);
    check("t3_ovf_now", {31'd0, overflow}, 1);
    check("t3_busy_drop", {31'd0, busy}, 1);
    drive(1, 1, 8'h04, 0, 0);
    drive(1, 1, 8'h05, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("t3_ovf", {31'd0, overflow}, 1);
    check("t3_cnt", {28'd0, pkt_cnt}, 2);
    check("t3_mode", {31'd0, mode_lp}, 0);
    check("t3_busy", {31'd0, busy}, 0);
    exp_q.push_back(10'h1C0); exp_q.push_back(10'h2FF);
    drive(1, 1, 8'h03, 0, 0);
    drive(1, 1, 8'hFF, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("t3_clean_cnt", {28'd0, pkt_cnt}, 3);
    check("t3_ovf_sticky", {31'd0, overflow}, 1);

    // Empty burst and valid outside a burst
    drive(1, 0, 8'hAA, 0, 0);
    drive(1, 0, 8'hAA, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h55, 0, 0);
    drive(0, 1, 8'h55, 0, 0);
    check("t4_cnt", {28'd0, pkt_cnt}, 3);
    check("t4_busy", {31'd0, busy}, 0);

    // Reset mid-burst with lane_active held
    exp_q.push_back(10'h180);
    drive(1, 1, 8'h01, 0, 0);
    drive(1, 1, 8'h02, 0, 0);
    rst = 1'b1;
    drive(1, 1, 8'h03, 0, 0);
    drive(1, 1, 8'h04, 0, 0);
    rst = 1'b0;
    drive(1, 1, 8'h05, 0, 0);
    drive(1, 1, 8'h06, 0, 0);
    check("t5_busy_wait", {31'd0, busy}, 0);
    check("t5_cnt_rst", {28'd0, pkt_cnt}, 0);
    drive(0, 0, 8'h00, 0, 0);
    exp_q.push_back(10'h3F0);
    drive(1, 1, 8'h0F, 1, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("t5_cnt", {28'd0, pkt_cnt}, 1);
    check("t5_mode", {31'd0, mode_lp}, 1);

    // 17 one-byte bursts from reset: 4-bit counter wraps to 1
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back({2'b11, rev8(8'(i * 13 + 1))});
      drive(1, 1, 8'(i * 13 + 1), 0, 0);
      drive(0, 0, 8'h00, 0, 0);
      if (i == 15) check("t6_wrap0", {28'd0, pkt_cnt}, 0);
    end
    check("t6_cnt", {28'd0, pkt_cnt}, 1);

    // ovf_clr in the same cycle as a loss: set wins
    check("t7_ovf_pre", {31'd0, overflow}, 0);
    exp_q.push_back(10'h180);
    drive(1, 1, 8'h01, 0, 0);
    drive(1, 1, 8'h02, 0, 0);
    ovf_clr = 1'b1;
    drive(1, 1, 8'h03, 0, 1);
    ovf_clr = 1'b0;
    check("t7_ovf_set_wins", {31'd0, overflow}, 1);
    drive(0, 0, 8'h00, 0, 0);
    ovf_clr = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    ovf_clr = 1'b0;
    check("t7_ovf_clr", {31'd0, overflow}, 0);

    // Lost eop word
    drive(1, 1, 8'h01, 0, 0);
    drive(0, 0, 8'h00, 0, 1);
    check("t8_ovf", {31'd0, overflow}, 1);
    check("t8_cnt", {28'd0, pkt_cnt}, 1);
    check("t8_busy", {31'd0, busy}, 0);
    exp_q.push_back(10'h301);
    drive(1, 1, 8'h80, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("t8_clean_cnt", {28'd0, pkt_cnt}, 2);

    drive(0, 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
